// File: rtl/lag_flash_gen.sv
// lag_flash_gen: pixel stage behind the CRTC timing generator. It draws a
// white flash box and measures the time, in clk cycles, from the first box
// pixel leaving this block to a rising edge on the light sensor.
module lag_flash_gen #(
  parameter logic [31:0] MAX_CYCLES     = 32'd50_000_000,
  parameter int unsigned TIMEOUT_FRAMES = 4,
  parameter logic        SENSOR_ACTIVE  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pixel,
  input  logic [11:0] hcnt,
  input  logic [11:0] vcnt,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [1:0]  wr,
  input  logic [3:0]  address,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic        sensor,
  output logic [23:0] rgb,
  output logic        hblank_o,
  output logic        vblank_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_FLASH   = 3'd2,
    S_MEASURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [15:0] TO_FRAMES = 16'(TIMEOUT_FRAMES);

  state_t      state, state_nx;
  logic [31:0] result, result_nx;
  logic        done, done_nx;
  logic        timeout, timeout_nx;
  logic [15:0] frm_cnt, frm_nx;

  logic [11:0] box_x, box_y, box_w, box_h;
  logic        sens_meta, sens_sync, sens_prev;
  logic        hit;
  logic        ctrl_wr, start, abort;
  logic [12:0] x_end, y_end;
  logic        inbox, frame_start, draw_en, white_px;
  logic        unused_din;

  assign unused_din = ^din[15:12];

  assign ctrl_wr = wr[0] && (address == 4'd0);
  assign abort   = ctrl_wr && din[1];
  assign start   = ctrl_wr && din[0] && !din[1];

  // Box geometry registers, byte-lane writable, only [11:0] stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      box_x <= '0;
      box_y <= '0;
      box_w <= '0;
      box_h <= '0;
    end else begin
      if (wr[0]) begin
        case (address)
          4'd1: box_x[7:0] <= din[7:0];
          4'd2: box_y[7:0] <= din[7:0];
          4'd3: box_w[7:0] <= din[7:0];
          4'd4: box_h[7:0] <= din[7:0];
          default: ;
        endcase
      end
      if (wr[1]) begin
        case (address)
          4'd1: box_x[11:8] <= din[11:8];
          4'd2: box_y[11:8] <= din[11:8];
          4'd3: box_w[11:8] <= din[11:8];
          4'd4: box_h[11:8] <= din[11:8];
          default: ;
        endcase
      end
    end
  end

  // Two-flop sensor synchroniser plus a history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sens_meta <= ~SENSOR_ACTIVE;
      sens_sync <= ~SENSOR_ACTIVE;
      sens_prev <= ~SENSOR_ACTIVE;
    end else begin
      sens_meta <= sensor;
      sens_sync <= sens_meta;
      sens_prev <= sens_sync;
    end
  end

  assign hit = (sens_sync == SENSOR_ACTIVE) && (sens_prev != SENSOR_ACTIVE);

  // Box bounds summed in 13 bits so X+W never wraps back into the screen.
  assign x_end       = {1'b0, box_x} + {1'b0, box_w};
  assign y_end       = {1'b0, box_y} + {1'b0, box_h};
  assign inbox       = !hblank && !vblank &&
                       (hcnt >= box_x) && ({1'b0, hcnt} < x_end) &&
                       (vcnt >= box_y) && ({1'b0, vcnt} < y_end);
  assign frame_start = ce_pixel && (hcnt == 12'd0) && (vcnt == 12'd0);
  // The box appears from the arming frame_start pixel itself.
  assign draw_en     = (state == S_FLASH) || (state == S_MEASURE) ||
                       ((state == S_ARM) && frame_start);
  assign white_px    = ce_pixel && draw_en && inbox;

  // Pixel pipe: one ce_pixel of latency, outputs hold between enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb      <= '0;
      hblank_o <= 1'b0;
      vblank_o <= 1'b0;
      hsync_o  <= 1'b0;
      vsync_o  <= 1'b0;
    end else if (ce_pixel) begin
      rgb      <= white_px ? '1 : '0;
      hblank_o <= hblank;
      vblank_o <= vblank;
      hsync_o  <= hsync;
      vsync_o  <= vsync;
    end
  end

  // FSM and measurement state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      result  <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
      frm_cnt <= '0;
    end else begin
      state   <= state_nx;
      result  <= result_nx;
      done    <= done_nx;
      timeout <= timeout_nx;
      frm_cnt <= frm_nx;
    end
  end

  // Next-state logic; ABORT overrides everything, START only from IDLE/DONE.
  always_comb begin
    state_nx   = state;
    result_nx  = result;
    done_nx    = done;
    timeout_nx = timeout;
    frm_nx     = frm_cnt;
    if (abort) begin
      state_nx   = S_IDLE;
      done_nx    = 1'b0;
      timeout_nx = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_nx   = S_ARM;
            result_nx  = '0;
            done_nx    = 1'b0;
            timeout_nx = 1'b0;
            frm_nx     = '0;
          end
        end
        S_ARM: begin
          // A box pixel on the arming pixel already counts as the flash.
          if (frame_start) begin
            state_nx  = white_px ? S_MEASURE : S_FLASH;
            result_nx = '0;
          end
        end
        S_FLASH: begin
          if (white_px) begin
            state_nx  = S_MEASURE;
            result_nx = '0;
          end else if (frame_start) begin
            if ((frm_cnt + 16'd1) == TO_FRAMES) begin
              state_nx   = S_DONE;
              done_nx    = 1'b1;
              timeout_nx = 1'b1;
              result_nx  = '0;
            end else begin
              frm_nx = frm_cnt + 16'd1;
            end
          end
        end
        S_MEASURE: begin
          result_nx = result + 32'd1;
          if (hit) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else if ((result + 32'd1) == MAX_CYCLES) begin
            state_nx   = S_DONE;
            done_nx    = 1'b1;
            timeout_nx = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);

  // Register read mux.
  always_comb begin
    dout = '0;
    case (address)
      4'd1: dout = {4'h0, box_x};
      4'd2: dout = {4'h0, box_y};
      4'd3: dout = {4'h0, box_w};
      4'd4: dout = {4'h0, box_h};
      4'd5: dout = {10'd0, timeout, done, 1'b0, state};
      4'd6: dout = result[15:0];
      4'd7: dout = result[31:16];
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_lag_flash_gen.sv
// Bench for lag_flash_gen: free-running small-frame timing source with a
// pixel scoreboard, plus register-level scenarios for the measurement FSM.
module tb_lag_flash_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_pixel;
  logic [11:0] hcnt, vcnt;
  logic        hblank, vblank, hsync, vsync;
  logic [1:0]  wr;
  logic [3:0]  address;
  logic [15:0] din;
  logic [15:0] dout;
  logic        sensor;
  logic [23:0] rgb;
  logic        hblank_o, vblank_o, hsync_o, vsync_o, busy;

  lag_flash_gen #(
    .MAX_CYCLES(32'd200),
    .TIMEOUT_FRAMES(4),
    .SENSOR_ACTIVE(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel),
    .hcnt(hcnt), .vcnt(vcnt), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .wr(wr), .address(address),
    .din(din), .dout(dout), .sensor(sensor), .rgb(rgb),
    .hblank_o(hblank_o), .vblank_o(vblank_o), .hsync_o(hsync_o),
    .vsync_o(vsync_o), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic [3:0]  tim;
    bit          chk;
  } pix_t;

  pix_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned gh = 0, gv = 0, frames_tb = 0;
  int unsigned bx = 0, by = 0, bw = 0, bh = 0;
  int          mode = 0;      // 0 no box, 1 armed, 2 drawing
  bit          chk_pix = 0;
  bit          white_seen = 0;
  bit          phase = 0;
  logic [23:0] last_rgb = '0;
  logic [3:0]  last_tim = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit in_box(input int unsigned h, input int unsigned v);
    return (h < 16) && (v < 8) && (h >= bx) && (h < bx + bw) && (v >= by) && (v < by + bh);
  endfunction

  // Timing source (20x10 frame, ce every other clock) and pixel scoreboard.
  initial begin : gen
    pix_t e;
    ce_pixel = 0; hcnt = '0; vcnt = '0;
    hblank = 0; vblank = 0; hsync = 0; vsync = 0;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          check("rgb", {8'h0, rgb}, {8'h0, e.rgb});
          check("timing", {28'h0, hblank_o, vblank_o, hsync_o, vsync_o}, {28'h0, e.tim});
        end
      end
      if (rgb == 24'hFFFFFF) white_seen = 1;
      phase = !phase;
      ce_pixel = phase;
      if (phase) begin
        hcnt = 12'(gh); vcnt = 12'(gv);
        hblank = (gh >= 16); vblank = (gv >= 8);
        hsync = (gh == 17) || (gh == 18); vsync = (gv == 9);
        if (gh == 0 && gv == 0) begin
          frames_tb++;
          if (mode == 1) mode = 2;
        end
        last_rgb = (mode == 2 && in_box(gh, gv)) ? 24'hFFFFFF : 24'h000000;
        last_tim = {hblank, vblank, hsync, vsync};
        if (gh == 19) begin
          gh = 0;
          gv = (gv == 9) ? 0 : gv + 1;
        end else gh = gh + 1;
      end
      if (!reset_n) begin
        last_rgb = '0;
        last_tim = '0;
      end
      q.push_back('{last_rgb, last_tim, chk_pix});
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reg_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] w);
    address = a; din = d; wr = w;
    @(posedge clk); #2;
    wr = 2'b00;
  endtask

  task automatic reg_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
    address = a; #1;
    check(tag, {16'h0, dout}, {16'h0, exp});
  endtask

  task automatic set_box(input int unsigned x, input int unsigned y, input int unsigned w, input int unsigned h);
    reg_write(4'd1, 16'(x), 2'b11); bx = x;
    reg_write(4'd2, 16'(y), 2'b11); by = y;
    reg_write(4'd3, 16'(w), 2'b11); bw = w;
    reg_write(4'd4, 16'(h), 2'b11); bh = h;
  endtask

  task automatic wait_mid_frame();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (gv == 3 && gh == 4) return;
    end
    check("mid_frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_white();
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #2;
      if (white_seen) return;
    end
    check("white_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      address = 4'd5; #1;
      if (dout[4]) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input int unsigned target);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (frames_tb >= target) return;
    end
    check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_run();
    wait_mid_frame();
    white_seen = 0;
    mode = 1;
    reg_write(4'd0, 16'h0001, 2'b01);
  endtask

  initial begin : main
    int unsigned f0;
    reset_n = 0; sensor = 0; wr = 2'b00; address = '0; din = '0;
    repeat (5) @(posedge clk);
    #2;
    check("rst_rgb", {8'h0, rgb}, 32'h0);
    check("rst_sync", {28'h0, hblank_o, vblank_o, hsync_o, vsync_o}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reg_check("rst_status", 4'd5, 16'h0000);
    reg_check("rst_result", 4'd6, 16'h0000);
    reset_n = 1;
    repeat (3) @(posedge clk);
    #2;

    // Register file behaviour.
    reg_write(4'd1, 16'hFFFF, 2'b11);
    reg_check("box_x_mask", 4'd1, 16'h0FFF);
    reg_write(4'd3, 16'hABCD, 2'b10);
    reg_check("box_w_hibyte", 4'd3, 16'h0B00);
    reg_check("ctrl_read", 4'd0, 16'h0000);
    reg_check("unused_addr", 4'd9, 16'h0000);
    set_box(10, 5, 4, 2);
    reg_check("box_y", 4'd2, 16'h0005);
    chk_pix = 1;

    // Box drawing, then sensor hit 150 clocks after the first white pixel.
    start_run();
    reg_check("arm_status", 4'd5, 16'h0001);
    check("arm_busy", {31'h0, busy}, 32'd1);
    wait_white();
    reg_check("measure_status", 4'd5, 16'h0003);
    repeat (149) @(posedge clk);
    #2 sensor = 1;
    wait_done();
    mode = 0;
    reg_check("hit_result_lo", 4'd6, 16'd152);
    reg_check("hit_result_hi", 4'd7, 16'd0);
    reg_check("hit_status", 4'd5, 16'h0014);
    check("done_busy", {31'h0, busy}, 32'd0);
    sensor = 0;
    wait_frames(frames_tb + 2);

    // Hit on the same cycle the count reaches MAX_CYCLES: hit wins.
    start_run();
    reg_check("rearm_status", 4'd5, 16'h0001);
    reg_check("rearm_result", 4'd6, 16'd0);
    wait_white();
    repeat (197) @(posedge clk);
    #2 sensor = 1;
    wait_done();
    mode = 0;
    reg_check("tie_result", 4'd6, 16'd200);
    reg_check("tie_status", 4'd5, 16'h0014);
    sensor = 0;
    wait_frames(frames_tb + 2);

    // Sensor held active through the run: no hit, MAX_CYCLES timeout.
    sensor = 1;
    repeat (10) @(posedge clk);
    start_run();
    wait_white();
    wait_done();
    mode = 0;
    reg_check("max_result", 4'd6, 16'd200);
    reg_check("max_status", 4'd5, 16'h0034);
    sensor = 0;
    wait_frames(frames_tb + 2);

    // Empty box: timeout after TIMEOUT_FRAMES frame starts in FLASH.
    reg_write(4'd3, 16'h0000, 2'b11); bw = 0;
    start_run();
    f0 = frames_tb;
    wait_frames(f0 + 4);
    repeat (3) @(posedge clk);
    #2;
    reg_check("flash_3frames", 4'd5, 16'h0002);
    wait_frames(f0 + 5);
    repeat (3) @(posedge clk);
    #2;
    reg_check("empty_status", 4'd5, 16'h0034);
    reg_check("empty_result", 4'd6, 16'd0);
    mode = 0;
    reg_write(4'd3, 16'h0004, 2'b11); bw = 4;
    wait_frames(frames_tb + 1);

    // START ignored mid-measure, START+ABORT aborts with result retained.
    start_run();
    wait_white();
    chk_pix = 0;
    repeat (20) @(posedge clk);
    #2;
    reg_write(4'd0, 16'h0001, 2'b01);
    reg_check("start_ignored", 4'd5, 16'h0003);
    reg_write(4'd0, 16'h0003, 2'b01);
    mode = 0;
    chk_pix = 1;
    reg_check("abort_status", 4'd5, 16'h0000);
    reg_check("abort_result", 4'd6, 16'd21);
    check("abort_busy", {31'h0, busy}, 32'd0);
    wait_frames(frames_tb + 2);

    // Asynchronous reset in the middle of a measurement.
    start_run();
    wait_white();
    chk_pix = 0;
    repeat (5) @(posedge clk);
    #2 reset_n = 0;
    #1;
    check("midrst_rgb", {8'h0, rgb}, 32'h0);
    check("midrst_sync", {28'h0, hblank_o, vblank_o, hsync_o, vsync_o}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    reg_check("midrst_status", 4'd5, 16'h0000);
    reg_check("midrst_result_lo", 4'd6, 16'h0000);
    reg_check("midrst_result_hi", 4'd7, 16'h0000);
    reg_check("midrst_box_x", 4'd1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
